// File: rtl/ift_pkg.sv
// Shared types and constants for the IFT trace capture block.
// The record layout is {ts, taint, data}, most significant field first.
package ift_pkg;

  localparam int unsigned IFT_DWIDTH = 2;
  localparam int unsigned IFT_TWIDTH = 32;
  localparam int unsigned IFT_TSW    = 16;
  localparam int unsigned IFT_RECW   = IFT_TSW + IFT_TWIDTH + IFT_DWIDTH;

  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  typedef struct packed {
    logic [IFT_TSW-1:0]    ts;
    logic [IFT_TWIDTH-1:0] taint;
    logic [IFT_DWIDTH-1:0] data;
  } ift_rec_t;

endpackage

// File: rtl/ift_sync_fifo.sv
// Synchronous FIFO with a registered head entry and registered status flags.
// Push into an empty FIFO becomes visible one cycle later; there is no bypass path.
module ift_sync_fifo #(
  parameter int unsigned WIDTH = 50,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;
  logic             r_full;

  logic [CW-1:0]    w_count_n;
  logic [AW-1:0]    w_rd_ptr_n;
  logic [WIDTH-1:0] w_head_n;

  // The head register is preloaded with whatever will sit at the read pointer
  // after this edge, taking the incoming word when it lands in that slot.
  always_comb begin
    w_count_n  = r_count + CW'(i_push) - CW'(i_pop);
    w_rd_ptr_n = r_rd_ptr + AW'(i_pop);
    w_head_n   = r_mem[w_rd_ptr_n];
    if (i_push && (w_rd_ptr_n == r_wr_ptr)) begin
      w_head_n = i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_head   <= w_head_n;
      r_valid  <= (w_count_n != '0);
      r_full   <= (w_count_n == CW'(DEPTH));
    end
  end

  assign o_head  = r_head;
  assign o_valid = r_valid;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/ift_trace_capture.sv
// Samples DUT data and taint each cycle and queues time-stamped change records.
// Records that find the FIFO full (and not draining this cycle) are counted as drops.
module ift_trace_capture
  import ift_pkg::*;
#(
  parameter int unsigned DWIDTH = IFT_DWIDTH,
  parameter int unsigned TWIDTH = IFT_TWIDTH,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TSW    = IFT_TSW
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      MODE_ALL,
  input  logic [DWIDTH-1:0]         Q,
  input  logic [TWIDTH-1:0]         Q_t,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [TSW+TWIDTH+DWIDTH-1:0] OUT_DATA,
  output logic                      FULL,
  output logic                      OVERFLOW,
  output logic [7:0]                DROP_CNT
);

  localparam int unsigned RECW = TSW + TWIDTH + DWIDTH;
  localparam int unsigned CW   = $clog2(DEPTH) + 1;

  logic [TSW-1:0]    r_ts;
  logic [DWIDTH-1:0] r_prev_q;
  logic [TWIDTH-1:0] r_prev_qt;
  logic              r_first;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  logic              w_valid;
  logic              w_full;
  logic [CW-1:0]     w_count;
  logic [RECW-1:0]   w_head;
  logic [RECW-1:0]   w_rec;
  logic              w_change;
  logic              w_req;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  assign w_rec    = {r_ts, Q_t, Q};
  assign w_change = r_first || (Q != r_prev_q) || (Q_t != r_prev_qt);
  assign w_req    = EN && (MODE_ALL || w_change);
  assign w_pop    = w_valid && OUT_READY;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign w_push   = w_req && ((w_count != CW'(DEPTH)) || w_pop);
  assign w_drop   = w_req && !w_push;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ts       <= '0;
      r_prev_q   <= '0;
      r_prev_qt  <= '0;
      r_first    <= 1'b1;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_ts <= r_ts + TSW'(1);
      if (EN) begin
        r_prev_q  <= Q;
        r_prev_qt <= Q_t;
        r_first   <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != DROP_CNT_MAX) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  ift_sync_fifo #(
    .WIDTH (RECW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_rec),
    .o_head  (w_head),
    .o_valid (w_valid),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign OUT_VALID = w_valid;
  assign OUT_DATA  = w_head;
  assign FULL      = w_full;
  assign OVERFLOW  = r_overflow;
  assign DROP_CNT  = r_drop_cnt;

endmodule
